// File: rtl/decay_pkg.sv
// Shared types and constants for the current-decay scheduler.
// Holds the Q4.12 fixed-point defaults, FSM state and MAC mode types, and the saturate helpers.
// No logic of its own; the helpers are pure functions.
package decay_pkg;

  localparam int DATA_W = 17;
  localparam int FRAC_W = 12;

  typedef logic signed [DATA_W-1:0] fix_t;

  // ~0.95 in Q4.12
  localparam fix_t DECAY_RESET = 17'sd3891;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    MAC_MUL = 1'b0,
    MAC_ADD = 1'b1
  } mac_mode_t;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic longint sat_clamp(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // High when v does not fit in a w-bit signed number.
  function automatic logic sat_hit(input longint v, input int w);
    return (sat_clamp(v, w) != v);
  endfunction

endpackage

// File: rtl/decay_mac.sv
// Shared arithmetic unit: signed multiply + floor shift, or signed add, then fit to DATA_W.
// Latency: purely combinational.
// Backpressure: none; result follows operands in the same cycle.
// Ports: mode (MAC_MUL / MAC_ADD), a, b operands, res result, sat = result was clamped.
// Build option DECAY_SAT_EN: defined -> clamp and flag; undefined -> two's-complement wrap, sat=0.
module decay_mac
  import decay_pkg::*;
#(
  parameter int DATA_W = decay_pkg::DATA_W,
  parameter int FRAC_W = decay_pkg::FRAC_W
) (
  input  mac_mode_t                 mode,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  output logic signed [DATA_W-1:0]  res,
  output logic                      sat
);

  logic signed [2*DATA_W-1:0] prod;
  longint                     wide;

  always_comb begin
    prod = a * b;
    // Arithmetic shift on the sign-extended product gives floor rounding.
    if (mode == MAC_MUL) wide = longint'(prod) >>> FRAC_W;
    else                 wide = longint'(a) + longint'(b);
`ifdef DECAY_SAT_EN
    res = DATA_W'(sat_clamp(wide, DATA_W));
    sat = sat_hit(wide, DATA_W);
`else
    res = DATA_W'(wide);
    sat = 1'b0;
`endif
  end

endmodule

// File: rtl/decay_sched.sv
// Time-multiplexed synaptic-current decay: one neuron per cycle through a shared MAC on each step.
// Latency: out_curr for neuron k appears 1 cycle after it is processed; sweep = NUM_NEURONS + 1 cycles.
// Backpressure: injections accepted only while idle (inj_ready); step/cfg ignored while busy.
// Ports: clk/rst (async, active-high); step starts a sweep; cfg_we/cfg_decay load the decay factor;
//        inj_* add current to one neuron; out_valid/out_addr/out_curr stream decayed currents;
//        busy, done (last-neuron pulse), sat_err (sticky). Build option: DECAY_SAT_EN.
module decay_sched
  import decay_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = decay_pkg::DATA_W,
  parameter int FRAC_W      = decay_pkg::FRAC_W,
  parameter logic signed [DATA_W-1:0] DECAY_RESET = DATA_W'(decay_pkg::DECAY_RESET)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step,
  input  logic                      cfg_we,
  input  logic signed [DATA_W-1:0]  cfg_decay,
  input  logic                      inj_valid,
  output logic                      inj_ready,
  input  logic [ADDR_W-1:0]         inj_addr,
  input  logic signed [DATA_W-1:0]  inj_curr,
  output logic                      busy,
  output logic                      out_valid,
  output logic [ADDR_W-1:0]         out_addr,
  output logic signed [DATA_W-1:0]  out_curr,
  output logic                      done,
  output logic                      sat_err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

  state_t                     state;
  logic [ADDR_W-1:0]          idx;
  logic signed [DATA_W-1:0]   decay;
  logic signed [DATA_W-1:0]   mem [NUM_NEURONS];

  logic                       in_sweep;
  logic                       inj_hit;
  logic [ADDR_W-1:0]          rd_addr;
  mac_mode_t                  mac_mode;
  logic signed [DATA_W-1:0]   mac_a;
  logic signed [DATA_W-1:0]   mac_b;
  logic signed [DATA_W-1:0]   mac_res;
  logic                       mac_sat;

  assign in_sweep  = (state == SWEEP);
  assign busy      = (state != IDLE);
  assign inj_ready = (state == IDLE) && !step;
  // Out-of-range addresses still handshake but never touch the array.
  assign inj_hit   = inj_valid && inj_ready && (int'(inj_addr) < NUM_NEURONS);

  // Sweeps and injections never overlap, so one MAC serves both.
  assign rd_addr  = in_sweep ? idx : inj_addr;
  assign mac_mode = in_sweep ? MAC_MUL : MAC_ADD;
  assign mac_a    = mem[rd_addr];
  assign mac_b    = in_sweep ? decay : inj_curr;

  decay_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .mode (mac_mode),
    .a    (mac_a),
    .b    (mac_b),
    .res  (mac_res),
    .sat  (mac_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      decay     <= DECAY_RESET;
      sat_err   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_addr  <= '0;
      out_curr  <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) decay <= cfg_decay;
          if (step) begin
            state <= SWEEP;
            idx   <= '0;
          end else if (inj_hit) begin
            mem[inj_addr] <= mac_res;
            if (mac_sat) sat_err <= 1'b1;
          end
        end
        SWEEP: begin
          mem[idx]  <= mac_res;
          if (mac_sat) sat_err <= 1'b1;
          out_valid <= 1'b1;
          out_addr  <= idx;
          out_curr  <= mac_res;
          if (idx == LAST) begin
            // done is registered alongside the last neuron's output.
            state <= DONE;
            done  <= 1'b1;
            idx   <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decay_sched.sv
// Self-checking bench for decay_sched: directed scenarios plus randomized rounds against a reference model.
// The model holds currents as plain integers and applies decay/injection arithmetic directly.
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
module tb_decay_sched;

  localparam int N    = 16;
  localparam int DW   = 17;
  localparam longint MAXV = 65535;
  localparam longint MINV = -65536;

  logic              clk;
  logic              rst;
  logic              step;
  logic              cfg_we;
  logic signed [16:0] cfg_decay;
  logic              inj_valid;
  logic              inj_ready;
  logic [3:0]        inj_addr;
  logic signed [16:0] inj_curr;
  logic              busy;
  logic              out_valid;
  logic [3:0]        out_addr;
  logic signed [16:0] out_curr;
  logic              done;
  logic              sat_err;

  decay_sched dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .cfg_we    (cfg_we),
    .cfg_decay (cfg_decay),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .inj_addr  (inj_addr),
    .inj_curr  (inj_curr),
    .busy      (busy),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_curr  (out_curr),
    .done      (done),
    .sat_err   (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  longint mdl_mem [N];
  longint mdl_decay;
  bit     mdl_sat;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit overflows(input longint v);
`ifdef DECAY_SAT_EN
    return (v > MAXV) || (v < MINV);
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint fit(input longint v);
    longint r;
`ifdef DECAY_SAT_EN
    if (v > MAXV)      r = MAXV;
    else if (v < MINV) r = MINV;
    else               r = v;
`else
    r = v % 131072;
    if (r < 0) r += 131072;
    if (r > MAXV) r -= 131072;
`endif
    return r;
  endfunction

  // i * d / 4096 rounded toward minus infinity
  function automatic longint mul_floor(input longint c, input longint d);
    longint p;
    p = c * d;
    if (p >= 0) return p / 4096;
    else        return -((-p + 4095) / 4096);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl_mem[i] = 0;
    mdl_decay = 3891;
    mdl_sat   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input longint v);
    cfg_we    = 1'b1;
    cfg_decay = 17'(v);
    tick();
    cfg_we    = 1'b0;
    mdl_decay = v;
  endtask

  task automatic do_inj(input int a, input longint c);
    longint s;
    inj_valid = 1'b1;
    inj_addr  = 4'(a);
    inj_curr  = 17'(c);
    #1;
    check("inj_ready_idle", longint'(inj_ready), 1);
    tick();
    inj_valid = 1'b0;
    s = mdl_mem[a] + c;
    if (overflows(s)) mdl_sat = 1'b1;
    mdl_mem[a] = fit(s);
    check("sat_err_inj", longint'(sat_err), longint'(mdl_sat));
  endtask

  // Full sweep with junk (step, cfg, injections) thrown at the DUT while busy.
  task automatic run_sweep(input bit with_inj);
    longint exp_v [N];
    longint p;
    int     busy_cnt;
    for (int k = 0; k < N; k++) begin
      p = mul_floor(mdl_mem[k], mdl_decay);
      if (overflows(p)) mdl_sat = 1'b1;
      exp_v[k] = fit(p);
    end
    step      = 1'b1;
    inj_valid = with_inj;
    inj_addr  = 4'($urandom_range(N - 1));
    inj_curr  = 17'($urandom_range(131071));
    #1;
    check("inj_ready_step", longint'(inj_ready), 0);
    tick();
    step      = 1'b0;
    inj_valid = 1'b0;
    busy_cnt  = busy ? 1 : 0;
    check("first_valid", longint'(out_valid), 0);
    for (int k = 0; k < N; k++) begin
      step      = 1'($urandom_range(1));
      cfg_we    = 1'($urandom_range(1));
      cfg_decay = 17'($urandom_range(131071));
      inj_valid = 1'($urandom_range(1));
      #1;
      check("inj_ready_busy", longint'(inj_ready), 0);
      tick();
      check("out_valid", longint'(out_valid), 1);
      check("out_addr", longint'(out_addr), k);
      check("out_curr", longint'(out_curr), exp_v[k]);
      check("done", longint'(done), (k == N - 1) ? 1 : 0);
      if (busy) busy_cnt++;
    end
    // DONE cycle: step and cfg must still be ignored
    step   = 1'($urandom_range(1));
    cfg_we = 1'($urandom_range(1));
    tick();
    step      = 1'b0;
    cfg_we    = 1'b0;
    inj_valid = 1'b0;
    #1;
    check("busy_cycles", busy_cnt, N + 1);
    check("busy_end", longint'(busy), 0);
    check("valid_end", longint'(out_valid), 0);
    check("done_end", longint'(done), 0);
    check("inj_ready_after", longint'(inj_ready), 1);
    check("sat_err_sweep", longint'(sat_err), longint'(mdl_sat));
    for (int k = 0; k < N; k++) mdl_mem[k] = exp_v[k];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    step      = 1'b0;
    cfg_we    = 1'b0;
    cfg_decay = '0;
    inj_valid = 1'b0;
    inj_addr  = '0;
    inj_curr  = '0;
    model_reset();
    #2;
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_done", longint'(done), 0);
    check("rst_sat", longint'(sat_err), 0);
    check("rst_addr", longint'(out_addr), 0);
    check("rst_curr", longint'(out_curr), 0);
    check("rst_ready", longint'(inj_ready), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // All-zero sweep
    run_sweep(1'b0);

    // Half decay, symmetric currents, two sweeps
    do_cfg(2048);
    do_inj(3, 4096);
    do_inj(5, -4096);
    run_sweep(1'b0);
    check("addr3_half", mdl_mem[3], 2048);
    run_sweep(1'b0);
    check("addr5_quarter", mdl_mem[5], -1024);

    // Floor rounding of a negative product
    do_inj(0, -1);
    run_sweep(1'b0);

    // Back-to-back accumulation beyond range
    do_cfg(4096);
    do_inj(2, 60000);
    do_inj(2, 10000);
    run_sweep(1'b0);

    // step together with an injection
    do_inj(7, 1234);
    run_sweep(1'b1);

    // Reset in the middle of a sweep
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_done", longint'(done), 0);
    check("mid_rst_curr", longint'(out_curr), 0);
    check("mid_rst_addr", longint'(out_addr), 0);
    check("mid_rst_sat", longint'(sat_err), 0);
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_done", longint'(done), 0);
    run_sweep(1'b0);
    // Confirms decay returned to its reset value
    do_inj(9, 4096);
    run_sweep(1'b0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      do_cfg(longint'($urandom_range(10000)) - 5000);
      for (int j = 0; j < 6; j++) begin
        if (j > 0 && $urandom_range(2) == 0)
          do_inj(int'(inj_addr), longint'($urandom_range(131071)) - 65536);
        else
          do_inj(int'($urandom_range(N - 1)), longint'($urandom_range(131071)) - 65536);
      end
      run_sweep(1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
